// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the execute stage and the iterative mul/div unit.
//   start/op/a/b/flush : request side, driven by the pipeline (master)
//   busy/done/stall/result : status and result, driven by the unit (slave)
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, stall, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, stall, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with its own sequencing FSM.
// Multiplies by radix-2 shift-add and divides by restoring division, on operand magnitudes,
// one bit per cycle over XLEN cycles, then applies sign correction in FIX.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of muldiv_sequencer_if
//           start/op/a/b sampled in IDLE, flush aborts from any state,
//           busy (CALC/FIX), done (one-cycle pulse), stall (pipeline freeze), result (held)
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   acc_q;   // product high half / partial remainder
  logic [XLEN-1:0]   quo_q;   // multiplier shifting out, product low half / quotient
  logic [XLEN-1:0]   opnd_q;  // |b|: multiplicand or divisor
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  // Request decode (IDLE side)
  logic              in_signed_a, in_signed_b, in_sa, in_sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              b_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   acc_d, quo_d;

  // Sign fix-up and output selection
  logic [2*XLEN-1:0] prod, prod_s;
  logic              prod_neg;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    if (bus.op[2]) begin
      in_signed_a = ~bus.op[0];
      in_signed_b = ~bus.op[0];
    end else begin
      in_signed_a = (bus.op != OpMulhu);
      in_signed_b = (bus.op == OpMul) | (bus.op == OpMulh);
    end
    in_sa = in_signed_a & bus.a[XLEN-1];
    in_sb = in_signed_b & bus.b[XLEN-1];
    a_mag = in_sa ? (~bus.a + 1'b1) : bus.a;
    b_mag = in_sb ? (~bus.b + 1'b1) : bus.b;

    b_zero  = (bus.b == '0);
    div_ovf = ((bus.op == OpDiv) | (bus.op == OpRem)) &
              (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.b == '1);
    special = bus.op[2] & (b_zero | div_ovf);
    // op[1] selects remainder among the divide ops
    if (b_zero) special_res = bus.op[1] ? bus.a : '1;
    else        special_res = bus.op[1] ? '0 : bus.a;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (quo_q[0] ? opnd_q : '0)};
    div_shift = {acc_q, quo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      // Restoring step: keep the trial difference only if it did not go negative
      if (!div_diff[XLEN]) begin
        acc_d = div_diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = div_shift[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add: sum carry lands in acc MSB, sum LSB shifts into the low half
      acc_d = mul_sum[XLEN:1];
      quo_d = {mul_sum[0], quo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {acc_q, quo_q};
    prod_neg = (op_q == OpMulhsu) ? sa_q : (sa_q ^ sb_q);
    prod_s   = prod_neg ? (~prod + 1'b1) : prod;
    quo_s    = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
    rem_s    = sa_q ? (~acc_q + 1'b1) : acc_q;
    unique case (op_q)
      OpMul:                    fix_res = prod_s[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod_s[2*XLEN-1:XLEN];
      OpDiv, OpDivu:            fix_res = quo_s;
      default:                  fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      quo_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      // Abort wins over everything, including a start in the same cycle
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              op_q    <= bus.op;
              sa_q    <= in_sa;
              sb_q    <= in_sb;
              acc_q   <= '0;
              quo_q   <= a_mag;
              opnd_q  <= b_mag;
              cnt_q   <= CntW'(XLEN - 1);
              busy_q  <= 1'b1;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          result_q <= fix_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = ((state_q == StIdle) & bus.start & ~bus.flush) | busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op from IDLE (called at posedge+1). Returns result, cycles from start to done
  // (-1 on timeout) and whether stall was high in every cycle before done and low with done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    stall_ok = 1'b1;
    lat      = -1;
    res      = 'x;
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    #1;
    if (bus.stall !== 1'b1) stall_ok = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        res = bus.result;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", bus.result); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int l; bit s;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, l, s);
    n_vec++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result got %h exp ffffffeb", r); end
    n_vec++; if (l != 34) begin n_err++; $display("FAIL mul_latency got %0d exp 34", l); end
    n_vec++; if (!s) begin n_err++; $display("FAIL mul_stall got bad stall exp high until done"); end
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, s);
    n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu got %h exp fffffffe", r); end
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, l, s);
    n_vec++; if (r !== 32'h4000_0000) begin n_err++; $display("FAIL mulh got %h exp 40000000", r); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, r, l, s);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu got %h exp ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int l; bit s;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, l, s);
    n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div got %h exp fffffffd", r); end
    n_vec++; if (l != 34) begin n_err++; $display("FAIL div_latency got %0d exp 34", l); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, l, s);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem got %h exp ffffffff", r); end
    run_op(3'b101, 32'd100, 32'd7, r, l, s);
    n_vec++; if (r !== 32'd14) begin n_err++; $display("FAIL divu got %h exp 0000000e", r); end
    run_op(3'b111, 32'd100, 32'd7, r, l, s);
    n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL remu got %h exp 00000002", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int l; bit s;
    run_op(3'b101, 32'd5, 32'd0, r, l, s);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_by0 got %h exp ffffffff", r); end
    n_vec++; if (l != 1) begin n_err++; $display("FAIL divu_by0_latency got %0d exp 1", l); end
    n_vec++; if (!s) begin n_err++; $display("FAIL divu_by0_stall got bad stall exp start-cycle only"); end
    run_op(3'b110, 32'd5, 32'd0, r, l, s);
    n_vec++; if (r !== 32'd5) begin n_err++; $display("FAIL rem_by0 got %h exp 00000005", r); end
    n_vec++; if (l != 1) begin n_err++; $display("FAIL rem_by0_latency got %0d exp 1", l); end
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, l, s);
    n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf got %h exp 80000000", r); end
    n_vec++; if (l != 1) begin n_err++; $display("FAIL div_ovf_latency got %0d exp 1", l); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, l, s);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL rem_ovf got %h exp 00000000", r); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int l; bit s; int seen;
    run_op(3'b101, 32'd100, 32'd7, r, l, s);
    n_vec++; if (r !== 32'd14) begin n_err++; $display("FAIL flush_pre got %h exp 0000000e", r); end
    // start together with flush in IDLE is not accepted
    bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_start_stall got %b exp 0", bus.stall); end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got %b exp 0", bus.busy); end
    // abort mid-CALC
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL flush_calc_busy got %b exp 1", bus.busy); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL flush_result got %h exp 0000000e", bus.result); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_no_done got %0d pulses exp 0", seen); end
    run_op(3'b000, 32'd3, 32'd5, r, l, s);
    n_vec++; if (r !== 32'd15) begin n_err++; $display("FAIL flush_after got %h exp 0000000f", r); end
    n_vec++; if (l != 34) begin n_err++; $display("FAIL flush_after_latency got %0d exp 34", l); end
  endtask

  task automatic test_reset_mid();
    bus.op = 3'b000; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
    n_vec++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL rstmid_result got %h exp 0", bus.result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_change();
    int lat;
    lat = -1;
    bus.op = 3'b101; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (n == 3) begin bus.op = 3'b000; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1; end
      if (n == 5) begin bus.op = 3'b111; bus.a = 32'd55; bus.b = 32'd3; end
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    n_vec++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL latched_result got %h exp 0000000e", bus.result); end
    n_vec++; if (lat != 34) begin n_err++; $display("FAIL latched_latency got %0d exp 34", lat); end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int l1, l2; bit s1, s2;
    run_op(3'b000, 32'd6, 32'd7, r1, l1, s1);
    run_op(3'b100, 32'd42, 32'hFFFF_FFFA, r2, l2, s2);
    n_vec++; if (r1 !== 32'd42) begin n_err++; $display("FAIL b2b_first got %h exp 0000002a", r1); end
    n_vec++; if (r2 !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL b2b_second got %h exp fffffff9", r2); end
    n_vec++; if (l2 != 34) begin n_err++; $display("FAIL b2b_latency got %0d exp 34", l2); end
    n_vec++; if (!(s1 && s2)) begin n_err++; $display("FAIL b2b_stall got bad stall exp high until done"); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_ignore_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
